// File: rtl/qea_host_sequencer.sv
// Host-side bring-up sequencer for one QEA instance: loads gate context, seeds the
// state RAM with a basis state, runs the engine, and streams the final state out.
module qea_host_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int READ_LAT                = 1,
    parameter int CNT_WIDTH               = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
    input  logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] i_init_index,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]         i_ctx_num,
    input  logic                                     i_ctx_valid,
    output logic                                     o_ctx_ready,
    input  logic [2*DATA_WIDTH-1:0]                  i_ctx_data,
    output logic                                     o_ctx_en,
    output logic                                     o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]       o_ctx_addr,
    output logic [2*DATA_WIDTH-1:0]                  o_ctx_data,
    output logic                                     o_state_ena,
    output logic                                     o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]           o_state_dina,
    output logic                                     o_start,
    input  logic                                     i_complete,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]           i_state_dout,
    output logic                                     o_rd_valid,
    input  logic                                     i_rd_ready,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]           o_rd_data,
    output logic                                     o_rd_last,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_error,
    output logic [CNT_WIDTH-1:0]                     o_cycle_count
);

    // state      | meaning
    // IDLE       | waiting for i_go
    // LOAD_CTX   | accepting context words into context RAM
    // INIT_STATE | writing the basis state, one word per cycle
    // START      | one-cycle start pulse to the QEA
    // RUN        | counting cycles until i_complete
    // READ_REQ   | issuing a state RAM read for word j
    // READ_WAIT  | covering the RAM read latency
    // READ_OUT   | presenting word j until the host takes it
    // DONE       | one-cycle completion pulse
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD_CTX   = 4'd1;
    localparam logic [3:0] S_INIT_STATE = 4'd2;
    localparam logic [3:0] S_START      = 4'd3;
    localparam logic [3:0] S_RUN        = 4'd4;
    localparam logic [3:0] S_READ_REQ   = 4'd5;
    localparam logic [3:0] S_READ_WAIT  = 4'd6;
    localparam logic [3:0] S_READ_OUT   = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam int IDX_W  = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int WORD_W = PE_NUM * 2 * DATA_WIDTH;
    localparam int LAT_W  = $clog2(READ_LAT + 1);
    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(IDX_W);
    localparam logic [GATE_CONTEXT_ADDR_WIDTH:0] CTX_MAX = {1'b1, {GATE_CONTEXT_ADDR_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONE_REAL = DATA_WIDTH'(1) << NUM_FRAC_BIT;

    logic [3:0]                         r_state;
    logic [GATE_CONTEXT_ADDR_WIDTH:0]   r_ctx_num;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_k;
    logic [STATE_ADDR_WIDTH-1:0]        r_j;
    logic [STATE_ADDR_WIDTH-1:0]        r_word_last;
    logic [STATE_ADDR_WIDTH-1:0]        r_init_word;
    logic [PE_NUM_WIDTH-1:0]            r_init_slot;
    logic [LAT_W-1:0]                   r_lat;
    logic [WORD_W-1:0]                  r_rd_data;
    logic [CNT_WIDTH-1:0]               r_cycle_count;
    logic                               r_error;

    logic                               w_cfg_bad;
    logic [MAX_QBIT_WIDTH-1:0]          w_shift;
    logic [STATE_ADDR_WIDTH:0]          w_words;
    logic [STATE_ADDR_WIDTH-1:0]        w_word_last;
    logic [GATE_CONTEXT_ADDR_WIDTH:0]   w_k_next;
    logic                               w_ctx_we;
    logic                               w_init_we;
    logic                               w_rd_req;
    logic                               w_j_last;
    logic [WORD_W-1:0]                  w_init_word;

    assign w_cfg_bad = (i_qbit_num < QBIT_MIN) || (i_qbit_num > QBIT_MAX) ||
                       ((i_init_index >> i_qbit_num) != '0) || (i_ctx_num > CTX_MAX);
    // W-1 for the largest configuration is all-ones in STATE_ADDR_WIDTH bits, so the
    // dropped top bit of w_words wraps correctly.
    assign w_shift     = i_qbit_num - QBIT_MIN;
    assign w_words     = {{STATE_ADDR_WIDTH{1'b0}}, 1'b1} << w_shift;
    assign w_word_last = w_words[STATE_ADDR_WIDTH-1:0] - 1'b1;
    assign w_k_next    = {1'b0, r_k} + 1'b1;

    assign w_ctx_we  = (r_state == S_LOAD_CTX) && i_ctx_valid;
    assign w_init_we = (r_state == S_INIT_STATE);
    assign w_rd_req  = (r_state == S_READ_REQ);
    assign w_j_last  = (r_j == r_word_last);

    // Slot 0 sits in the most significant lanes; real part is the upper half of a slot.
    always_comb begin
        w_init_word = '0;
        if (r_j == r_init_word) begin
            for (int p = 0; p < PE_NUM; p++) begin
                if (r_init_slot == PE_NUM_WIDTH'(p))
                    w_init_word[(PE_NUM-1-p)*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH] = ONE_REAL;
            end
        end
    end

    assign o_ctx_ready   = (r_state == S_LOAD_CTX);
    assign o_ctx_en      = w_ctx_we;
    assign o_ctx_wea     = w_ctx_we;
    assign o_ctx_addr    = w_ctx_we ? r_k : '0;
    assign o_ctx_data    = w_ctx_we ? i_ctx_data : '0;
    assign o_state_ena   = w_init_we | w_rd_req;
    assign o_state_wea   = w_init_we;
    assign o_state_addra = (w_init_we | w_rd_req) ? r_j : '0;
    assign o_state_dina  = w_init_we ? w_init_word : '0;
    assign o_start       = (r_state == S_START);
    assign o_rd_valid    = (r_state == S_READ_OUT);
    assign o_rd_data     = r_rd_data;
    assign o_rd_last     = (r_state == S_READ_OUT) && w_j_last;
    assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done        = (r_state == S_DONE);
    assign o_error       = r_error;
    assign o_cycle_count = r_cycle_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ctx_num     <= '0;
            r_k           <= '0;
            r_j           <= '0;
            r_word_last   <= '0;
            r_init_word   <= '0;
            r_init_slot   <= '0;
            r_lat         <= '0;
            r_rd_data     <= '0;
            r_cycle_count <= '0;
            r_error       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_go) begin
                    r_error       <= w_cfg_bad;
                    r_cycle_count <= '0;
                    r_ctx_num     <= i_ctx_num;
                    r_word_last   <= w_word_last;
                    r_init_word   <= i_init_index[IDX_W-1:PE_NUM_WIDTH];
                    r_init_slot   <= i_init_index[PE_NUM_WIDTH-1:0];
                    r_k           <= '0;
                    r_j           <= '0;
                    if (w_cfg_bad)
                        r_state <= S_DONE;
                    else if (i_ctx_num == '0)
                        r_state <= S_INIT_STATE;
                    else
                        r_state <= S_LOAD_CTX;
                end
                S_LOAD_CTX: if (i_ctx_valid) begin
                    r_k <= w_k_next[GATE_CONTEXT_ADDR_WIDTH-1:0];
                    if (w_k_next == r_ctx_num)
                        r_state <= S_INIT_STATE;
                end
                S_INIT_STATE: begin
                    if (w_j_last) begin
                        r_j     <= '0;
                        r_state <= S_START;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                S_START: r_state <= S_RUN;
                S_RUN: begin
                    if (r_cycle_count != '1)
                        r_cycle_count <= r_cycle_count + 1'b1;
                    if (i_complete)
                        r_state <= S_READ_REQ;
                end
                S_READ_REQ: begin
                    r_lat   <= LAT_W'(READ_LAT - 1);
                    r_state <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (r_lat == '0) begin
                        r_rd_data <= i_state_dout;
                        r_state   <= S_READ_OUT;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                S_READ_OUT: if (i_rd_ready) begin
                    if (w_j_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_j     <= r_j + 1'b1;
                        r_state <= S_READ_REQ;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
